fetch_queue: RTL and testbench

- Instruction prefetch stage between imem and the processor's F/D latch.
- Issues sequential fetch addresses to imem and captures the instruction words one cycle later.
- Buffers {PC, PC+1, instr} tuples in a small FIFO and presents the head to the decode latch with a valid/ready handshake.
- Accepts a redirect (j/jr/jal/bex resolved in X) that flushes all buffered and in-flight fetches and restarts at the target.

---
 rtl/fetch_queue_pkg.sv | 14 +
 rtl/fetch_queue_if.sv | 26 ++
 rtl/fetch_queue_fifo.sv | 51 +++++
 rtl/fetch_queue.sv | 97 +++++++++
 tb/tb_fetch_queue.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared processor types for the fetch stage: word width, nop encoding and the
// buffered fetch entry.
package processor_pkg;

  localparam int unsigned WORD_W = 32;
  localparam logic [WORD_W-1:0] NOP_INSTR = 32'b0;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] pc_plus_one;
    logic [WORD_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch queue bus: imem address/data, redirect request and the decode-side
// valid/ready handshake carrying the head entry.
interface fetch_queue_if;
  import processor_pkg::*;

  logic [WORD_W-1:0] address_imem;
  logic [WORD_W-1:0] q_imem;
  logic              redirect_valid;
  logic [WORD_W-1:0] redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_pc;
  logic [WORD_W-1:0] out_pc_plus_one;
  logic [WORD_W-1:0] out_instr;

  modport master (
    output address_imem, out_valid, out_pc, out_pc_plus_one, out_instr,
    input  q_imem, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  address_imem, out_valid, out_pc, out_pc_plus_one, out_instr,
    output q_imem, redirect_valid, redirect_pc, out_ready
  );

endinterface

// File: rtl/fetch_queue_fifo.sv
// Power-of-two circular buffer of fetch entries with push/pop/flush and an
// occupancy count (0..DEPTH).
module fetch_fifo
  import processor_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CW    = PW + 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_entry,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty,
  output logic [CW-1:0] count
);

  fetch_entry_t      mem [DEPTH];
  logic [PW-1:0]     head_ptr;
  logic [PW-1:0]     tail_ptr;

  // Storage needs no reset: the head is only observed when count is nonzero.
  always_ff @(posedge clock) begin
    if (push && !flush) mem[tail_ptr] <= push_entry;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else if (flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (push) tail_ptr <= tail_ptr + PW'(1);
      if (pop)  head_ptr <= head_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head  = mem[head_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: sequential imem fetch, one-cycle capture into a
// FIFO, redirect flush. Optional counters enabled by FETCH_PERF_EN.
module fetch_queue
  import processor_pkg::*;
#(
  parameter int unsigned       DEPTH    = 4,
  parameter logic [WORD_W-1:0] RESET_PC = '0
) (
  input  logic clock,
  input  logic reset,
  fetch_queue_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [WORD_W-1:0] perf_flushes,
  output logic [WORD_W-1:0] perf_empty_cycles,
  output logic [WORD_W-1:0] perf_full_cycles
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned OW = CW + 1;

  logic [WORD_W-1:0] fetch_pc;
  logic [WORD_W-1:0] inflight_pc;
  logic              inflight;
  logic              push;
  logic              pop;
  logic              issue;
  logic              full;
  logic              empty;
  logic [CW-1:0]     count;
  logic [OW-1:0]     occupancy;
  fetch_entry_t      push_entry;
  fetch_entry_t      head;

  assign pop       = !empty && bus.out_ready && !bus.redirect_valid;
  assign push      = inflight && !bus.redirect_valid;
  assign occupancy = OW'(count) + OW'(inflight) - OW'(pop);
  assign issue     = (occupancy < OW'(DEPTH));

  assign push_entry = '{pc: inflight_pc, pc_plus_one: inflight_pc + 32'd1, instr: bus.q_imem};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .flush      (bus.redirect_valid),
    .push_entry (push_entry),
    .head       (head),
    .full       (full),
    .empty      (empty),
    .count      (count)
  );

  // Redirect outranks issue; an in-flight word is dropped by not pushing it.
  always_ff @(posedge clock) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (bus.redirect_valid) begin
      fetch_pc    <= bus.redirect_pc;
      inflight    <= 1'b0;
    end else if (issue) begin
      fetch_pc    <= fetch_pc + 32'd1;
      inflight    <= 1'b1;
      inflight_pc <= fetch_pc;
    end else begin
      inflight    <= 1'b0;
    end
  end

  assign bus.address_imem    = fetch_pc;
  assign bus.out_valid       = !empty;
  assign bus.out_pc          = empty ? '0 : head.pc;
  assign bus.out_pc_plus_one = empty ? '0 : head.pc_plus_one;
  assign bus.out_instr       = empty ? NOP_INSTR : head.instr;

  a_no_push_when_full : assert property (@(posedge clock) disable iff (!reset) push |-> !full);

`ifdef FETCH_PERF_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      perf_flushes      <= '0;
      perf_empty_cycles <= '0;
      perf_full_cycles  <= '0;
    end else begin
      if (bus.redirect_valid && perf_flushes != '1) perf_flushes <= perf_flushes + 32'd1;
      if (empty && bus.out_ready && perf_empty_cycles != '1)
        perf_empty_cycles <= perf_empty_cycles + 32'd1;
      if (full && perf_full_cycles != '1) perf_full_cycles <= perf_full_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized and directed checks of fetch_queue against a queue-based model of
// the prefetch rules; define FETCH_PERF_EN to also check the counters.
module tb_fetch_queue;
  import processor_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  fetch_queue_if bus ();

`ifdef FETCH_PERF_EN
  logic [31:0] perf_flushes, perf_empty_cycles, perf_full_cycles;
  int unsigned m_flushes, m_empty, m_full;
`endif

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
`ifdef FETCH_PERF_EN
    ,
    .perf_flushes      (perf_flushes),
    .perf_empty_cycles (perf_empty_cycles),
    .perf_full_cycles  (perf_full_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return (pc * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // imem: synchronous read, data one cycle after the address.
  always @(posedge clk) bus.q_imem <= instr_of(bus.address_imem);

  // Reference model: pending PCs in a queue, one optional outstanding fetch.
  logic [31:0] mq[$];
  logic [31:0] m_fpc;
  logic [31:0] m_ipc;
  bit          m_infl;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_fpc  = RESET_PC;
    m_ipc  = '0;
    m_infl = 1'b0;
`ifdef FETCH_PERF_EN
    m_flushes = 0; m_empty = 0; m_full = 0;
`endif
  endtask

  task automatic model_step(input bit rdy, input bit rv, input logic [31:0] rpc);
    bit pop;
    int occ;
`ifdef FETCH_PERF_EN
    if (rv) m_flushes++;
    if (mq.size() == 0 && rdy) m_empty++;
    if (mq.size() == DEPTH) m_full++;
`endif
    if (rv) begin
      mq.delete();
      m_infl = 1'b0;
      m_fpc  = rpc;
      return;
    end
    pop = (mq.size() != 0) && rdy;
    occ = mq.size() + int'(m_infl) - int'(pop);
    if (pop) void'(mq.pop_front());
    if (m_infl) mq.push_back(m_ipc);
    if (occ < DEPTH) begin
      m_infl = 1'b1;
      m_ipc  = m_fpc;
      m_fpc  = m_fpc + 32'd1;
    end else begin
      m_infl = 1'b0;
    end
  endtask

  // One clock: drive inputs, check outputs against the model, then advance the model.
  task automatic cycle(input bit rst_n, input bit rdy, input bit rv, input logic [31:0] rpc);
    bit v;
    @(negedge clk);
    rst                = rst_n;
    bus.out_ready      = rdy;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    #1;
    v = (mq.size() != 0);
    check("out_valid", 32'(bus.out_valid), 32'(v));
    check("out_pc", bus.out_pc, v ? mq[0] : 32'h0);
    check("out_pc_plus_one", bus.out_pc_plus_one, v ? mq[0] + 32'd1 : 32'h0);
    check("out_instr", bus.out_instr, v ? instr_of(mq[0]) : NOP_INSTR);
    check("address_imem", bus.address_imem, m_fpc);
`ifdef FETCH_PERF_EN
    check("perf_flushes", perf_flushes, m_flushes);
    check("perf_empty_cycles", perf_empty_cycles, m_empty);
    check("perf_full_cycles", perf_full_cycles, m_full);
`endif
    if (!rst_n) model_reset();
    else model_step(rdy, rv, rpc);
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 32'h0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    model_reset();

    // Reset, then streaming fill with out_ready high.
    do_reset();
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_addr", bus.address_imem, RESET_PC);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("fill_gap", 32'(bus.out_valid), 32'd0);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("fill_pc0", bus.out_pc, 32'h0);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0);

    // Decode stall: queue saturates and issue stops, then drains in order.
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    check("stall_addr", bus.address_imem, 32'd4);
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0);

    // Redirect with three buffered and one in flight.
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b1, 32'h40);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("redir_gap0", 32'(bus.out_valid), 32'd0);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("redir_gap1", 32'(bus.out_valid), 32'd0);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("redir_pc", bus.out_pc, 32'h40);
    check("redir_ppo", bus.out_pc_plus_one, 32'h41);

    // Redirect while popping and pushing in steady state.
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b1, 32'h100);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("flush_empty", 32'(bus.out_valid), 32'd0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0);

    // Address wrap past 0xFFFFFFFF.
    cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("wrap_pc_hi", bus.out_pc, 32'hFFFF_FFFF);
    check("wrap_ppo_hi", bus.out_pc_plus_one, 32'h0);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("wrap_pc_lo", bus.out_pc, 32'h0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0);

    // Reset mid-operation with the queue loaded and a redirect pending.
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 1'b1, 32'h77);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("midrst_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_addr", bus.address_imem, RESET_PC);
`ifdef FETCH_PERF_EN
    check("midrst_flushes", perf_flushes, 32'd0);
    check("midrst_full", perf_full_cycles, 32'd0);
`endif

    // Random traffic: ready, redirects and rare resets.
    for (int i = 0; i < 1500; i++) begin
      bit          r_rst, r_rdy, r_rv;
      logic [31:0] r_pc;
      r_rst = ($urandom_range(0, 199) != 0);
      r_rdy = ($urandom_range(0, 99) < 60);
      r_rv  = ($urandom_range(0, 99) < 5);
      r_pc  = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFE : $urandom();
      cycle(r_rst, r_rdy, r_rv, r_pc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
